uart_tx_arbiter: RTL

//  Shares the single 64-bit UART frame transmitter (UART_TX_DATA, star-trigger DSTARB line) between
//  NUM_REQ frame sources (ISA decoder, PXIe host path, trigger/status reporters). Each source owns a
//  one-frame holding register. A round-robin arbiter issues one frame at a time and tracks the

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one frame transmitter between NUM_REQ sources,
// each with a one-frame holding register and sticky overflow/timeout flags.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int BUSY_TO = 16
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic [NUM_REQ*DATA_W-1:0]     I_req_data,
    input  logic [NUM_REQ-1:0]            I_req_vld,
    output logic [NUM_REQ-1:0]            O_req_busy,
    input  logic                          I_ovf_clr,
    output logic [NUM_REQ-1:0]            O_ovf,
    input  logic                          I_tx_ready,
    output logic [DATA_W-1:0]             O_tx_data,
    output logic                          O_tx_en,
    output logic [$clog2(NUM_REQ)-1:0]    O_tx_src,
    output logic [31:0]                   O_frame_cnt,
    output logic                          O_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(BUSY_TO);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LO,
        ST_WAIT_HI
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TMR_W-1:0]     r_tmr;
    logic [TMR_W-1:0]     w_tmr_nxt;
    logic                 w_issue;
    logic                 w_to_hit;

    logic [NUM_REQ-1:0]   r_pend;
    logic [NUM_REQ-1:0]   w_pend_nxt;
    logic [NUM_REQ-1:0]   w_take;
    logic [NUM_REQ-1:0]   w_ovf_set;
    logic [IDX_W-1:0]     r_ptr;
    logic [DATA_W-1:0]    r_hold [NUM_REQ];
    logic [NUM_REQ-1:0]   r_ovf;
    logic                 r_timeout;
    logic [DATA_W-1:0]    r_tx_data;
    logic [IDX_W-1:0]     r_tx_src;
    logic                 r_tx_en;
    logic [31:0]          r_frame_cnt;

    logic                 w_gnt_vld;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [IDX_W-1:0]     w_scan;

    // Descending scan so the pending index closest to r_ptr is the last one written.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (r_pend[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_issue     = 1'b0;
        w_to_hit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (I_tx_ready && w_gnt_vld) begin
                    w_issue     = 1'b1;
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!I_tx_ready) begin
                    w_state_nxt = ST_WAIT_HI;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                    if (r_tmr == TMR_W'(BUSY_TO - 1)) begin
                        w_to_hit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (I_tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A strobe to the requester being granted this cycle refills its slot instead of overflowing.
    always_comb begin
        w_pend_nxt = r_pend;
        w_take     = '0;
        w_ovf_set  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_issue && (w_gnt_idx == IDX_W'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
            if (I_req_vld[i]) begin
                if (!r_pend[i] || (w_issue && (w_gnt_idx == IDX_W'(i)))) begin
                    w_take[i]     = 1'b1;
                    w_pend_nxt[i] = 1'b1;
                end else begin
                    w_ovf_set[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_take[i]) begin
                r_hold[i] <= I_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_pend      <= '0;
            r_ptr       <= '0;
            r_ovf       <= '0;
            r_timeout   <= 1'b0;
            r_tx_data   <= '0;
            r_tx_src    <= '0;
            r_tx_en     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_tx_en   <= w_issue;
            r_ovf     <= (I_ovf_clr ? '0 : r_ovf) | w_ovf_set;
            r_timeout <= (I_ovf_clr ? 1'b0 : r_timeout) | w_to_hit;
            if (w_issue) begin
                r_tx_data   <= r_hold[w_gnt_idx];
                r_tx_src    <= w_gnt_idx;
                r_ptr       <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
        end
    end

    assign O_req_busy  = r_pend;
    assign O_ovf       = r_ovf;
    assign O_timeout   = r_timeout;
    assign O_tx_data   = r_tx_data;
    assign O_tx_src    = r_tx_src;
    assign O_tx_en     = r_tx_en;
    assign O_frame_cnt = r_frame_cnt;

endmodule
